// File: rtl/calc_acc_bank.sv
// calc_acc_bank: NUM_ACC signed accumulators sharing one ALU, with debounced-edge buttons and a circular undo history.
// Build option: define CALC_SAT_EN to make add/sub saturate instead of wrapping.
module calc_acc_bank #(
   parameter int  WIDTH   = 16,
   parameter int  NUM_ACC = 4,
   parameter int  DEPTH   = 8,
   localparam int SEL_W   = $clog2(NUM_ACC),
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btnl,
   input  logic             btnc,
   input  logic             btnr,
   input  logic             btnd,
   input  logic             btnu,
   input  logic             undo,
   input  logic [SEL_W-1:0] sel,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] led,
   output logic             zero,
   output logic             ovf,
   output logic [CNT_W-1:0] hist_cnt
);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   // Button index: 0 = commit, 1 = clear, 2 = undo.
   logic [2:0] raw_btn;
   logic [2:0] pulse;
   assign raw_btn = {undo, btnu, btnd};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_sync
         logic sync1_reg;
         logic sync2_reg;
         logic prev_reg;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               prev_reg  <= 1'b0;
            end else begin
               sync1_reg <= raw_btn[gi];
               sync2_reg <= sync1_reg;
               prev_reg  <= sync2_reg;
            end
         end
         assign pulse[gi] = sync2_reg & ~prev_reg;
      end
   endgenerate

   logic commit_pulse;
   logic clear_pulse;
   logic undo_pulse;
   assign commit_pulse = pulse[0];
   assign clear_pulse  = pulse[1];
   assign undo_pulse   = pulse[2];

   logic [NUM_ACC-1:0][WIDTH-1:0] acc_bus;
   logic [WIDTH-1:0]              acc_cur;
   assign acc_cur = acc_bus[sel];

   // ALU between the selected accumulator and the switch operand
   logic [2:0]       op;
   logic [4:0]       shamt;
   logic             shift_big;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;

   assign op        = {btnl, btnc, btnr};
   assign shamt     = sw[4:0];
   assign shift_big = ({27'd0, shamt} >= 32'(WIDTH));
   assign sum       = acc_cur + sw;
   assign diff      = acc_cur - sw;
   assign add_ovf   = (acc_cur[WIDTH-1] == sw[WIDTH-1]) && (sum[WIDTH-1]  != acc_cur[WIDTH-1]);
   assign sub_ovf   = (acc_cur[WIDTH-1] != sw[WIDTH-1]) && (diff[WIDTH-1] != acc_cur[WIDTH-1]);

`ifdef CALC_SAT_EN
   // An overflowing add/sub always overflows away from the sign of the accumulator.
   logic [WIDTH-1:0] sat_val;
   assign sat_val = acc_cur[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

   always_comb begin
      alu_res = acc_cur;
      alu_ovf = 1'b0;
      case (op)
         3'b000: begin
            alu_ovf = add_ovf;
`ifdef CALC_SAT_EN
            alu_res = add_ovf ? sat_val : sum;
`else
            alu_res = sum;
`endif
         end
         3'b001: begin
            alu_ovf = sub_ovf;
`ifdef CALC_SAT_EN
            alu_res = sub_ovf ? sat_val : diff;
`else
            alu_res = diff;
`endif
         end
         3'b010: alu_res = acc_cur & sw;
         3'b011: alu_res = acc_cur | sw;
         3'b100: alu_res = acc_cur ^ sw;
         3'b101: alu_res = shift_big ? '0 : (acc_cur << shamt);
         3'b110: alu_res = shift_big ? {WIDTH{acc_cur[WIDTH-1]}}
                                     : WIDTH'($signed(acc_cur) >>> shamt);
         3'b111: alu_res = sw;
      endcase
   end

   // Undo history: circular LIFO, top_reg points at the next free slot.
   logic [SEL_W-1:0] hist_sel_mem [DEPTH];
   logic [WIDTH-1:0] hist_val_mem [DEPTH];
   logic [PTR_W-1:0] top_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             ovf_reg;
   logic [PTR_W-1:0] top_next;
   logic [PTR_W-1:0] top_prev;
   logic             push_en;
   logic             pop_en;
   logic [SEL_W-1:0] pop_sel;
   logic [WIDTH-1:0] pop_val;

   assign top_next = (top_reg == PTR_LAST) ? '0 : top_reg + 1'b1;
   assign top_prev = (top_reg == '0) ? PTR_LAST : top_reg - 1'b1;
   assign push_en  = clear_pulse | (~undo_pulse & commit_pulse);
   assign pop_en   = ~clear_pulse & undo_pulse & (cnt_reg != '0);
   // Read is asynchronous so a pop restores in the same edge it is seen.
   assign pop_sel  = hist_sel_mem[top_prev];
   assign pop_val  = hist_val_mem[top_prev];

   always_ff @(posedge clk) begin
      if (rst_n && push_en) begin
         hist_sel_mem[top_reg] <= sel;
         hist_val_mem[top_reg] <= acc_cur;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         top_reg <= '0;
         cnt_reg <= '0;
         ovf_reg <= 1'b0;
      end else begin
         if (push_en) begin
            top_reg <= top_next;
            if (cnt_reg != CNT_FULL) cnt_reg <= cnt_reg + 1'b1;
         end else if (pop_en) begin
            top_reg <= top_prev;
            cnt_reg <= cnt_reg - 1'b1;
         end
         if (clear_pulse) ovf_reg <= 1'b0;
         else if (!undo_pulse && commit_pulse) ovf_reg <= ovf_reg | alu_ovf;
      end
   end

   // Single accumulator write port, priority clear > undo > commit
   logic             acc_we;
   logic [SEL_W-1:0] acc_wsel;
   logic [WIDTH-1:0] acc_wdata;

   always_comb begin
      acc_we    = 1'b0;
      acc_wsel  = sel;
      acc_wdata = '0;
      if (clear_pulse) begin
         acc_we = 1'b1;
      end else if (undo_pulse) begin
         acc_we    = pop_en;
         acc_wsel  = pop_sel;
         acc_wdata = pop_val;
      end else if (commit_pulse) begin
         acc_we    = 1'b1;
         acc_wdata = alu_res;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_acc
         logic [WIDTH-1:0] val_reg;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               val_reg <= '0;
            end else if (acc_we && (acc_wsel == SEL_W'(gi))) begin
               val_reg <= acc_wdata;
            end
         end
         assign acc_bus[gi] = val_reg;
      end
   endgenerate

   assign led      = acc_cur;
   assign zero     = (acc_cur == '0);
   assign ovf      = ovf_reg;
   assign hist_cnt = cnt_reg;

endmodule

// File: tb/tb_calc_acc_bank.sv
// Directed bench for calc_acc_bank: expectations are queued as stimulus is applied and popped when outputs settle.
module tb_calc_acc_bank;
   localparam int WIDTH   = 16;
   localparam int NUM_ACC = 4;
   localparam int DEPTH   = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRA = 3'b110;
   localparam logic [2:0] OP_LD  = 3'b111;

`ifdef CALC_SAT_EN
   localparam logic [15:0] ADD_OVF_RES = 16'h7FFF;
   localparam logic [15:0] SUB_OVF_RES = 16'h8000;
`else
   localparam logic [15:0] ADD_OVF_RES = 16'h8000;
   localparam logic [15:0] SUB_OVF_RES = 16'h7FFF;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        btnl  = 1'b0;
   logic        btnc  = 1'b0;
   logic        btnr  = 1'b0;
   logic        btnd  = 1'b0;
   logic        btnu  = 1'b0;
   logic        undo  = 1'b0;
   logic [1:0]  sel   = 2'd0;
   logic [15:0] sw    = 16'd0;
   logic [15:0] led;
   logic        zero;
   logic        ovf;
   logic [3:0]  hist_cnt;

   calc_acc_bank #(.WIDTH(WIDTH), .NUM_ACC(NUM_ACC), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btnl     (btnl),
      .btnc     (btnc),
      .btnr     (btnr),
      .btnd     (btnd),
      .btnu     (btnu),
      .undo     (undo),
      .sel      (sel),
      .sw       (sw),
      .led      (led),
      .zero     (zero),
      .ovf      (ovf),
      .hist_cnt (hist_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [15:0] led;
      logic        zero;
      logic        ovf;
      logic [3:0]  cnt;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic exp_push(input string tag, input logic [15:0] l, input logic o, input logic [3:0] c);
      exp_t e;
      e.tag  = tag;
      e.led  = l;
      e.zero = (l == 16'd0);
      e.ovf  = o;
      e.cnt  = c;
      sb.push_back(e);
   endtask

   task automatic exp_check();
      exp_t e;
      vectors++;
      assert (sb.size() != 0) else begin
         miscompares++;
         $error("FAIL sb_empty: got %0d queued entries, required at least 1", sb.size());
      end
      if (sb.size() == 0) return;
      e = sb.pop_front();
      $display("step %s: led=%h zero=%b ovf=%b hist_cnt=%0d", e.tag, led, zero, ovf, hist_cnt);
      vectors++;
      assert (led === e.led) else begin
         miscompares++;
         $error("FAIL %s led: got %h required %h", e.tag, led, e.led);
      end
      vectors++;
      assert (zero === e.zero) else begin
         miscompares++;
         $error("FAIL %s zero: got %b required %b", e.tag, zero, e.zero);
      end
      vectors++;
      assert (ovf === e.ovf) else begin
         miscompares++;
         $error("FAIL %s ovf: got %b required %b", e.tag, ovf, e.ovf);
      end
      vectors++;
      assert (hist_cnt === e.cnt) else begin
         miscompares++;
         $error("FAIL %s hist_cnt: got %0d required %0d", e.tag, hist_cnt, e.cnt);
      end
   endtask

   // mask = {undo, btnu, btnd}; held long enough for one pulse, then released long enough to re-arm.
   task automatic press(input logic [2:0] mask);
      {undo, btnu, btnd} = mask;
      repeat (3) @(posedge clk);
      #1;
      {undo, btnu, btnd} = 3'b000;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic commit(input logic [2:0] op, input logic [1:0] s, input logic [15:0] v);
      {btnl, btnc, btnr} = op;
      sel = s;
      sw  = v;
      press(3'b001);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      exp_push("reset", 16'h0000, 1'b0, 4'd0);
      exp_check();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First commit latency: update lands two edges after the first sampling edge
      {btnl, btnc, btnr} = OP_ADD;
      sel  = 2'd0;
      sw   = 16'd5;
      btnd = 1'b1;
      @(posedge clk); #1;
      exp_push("lat_edge_n", 16'h0000, 1'b0, 4'd0);
      exp_check();
      @(posedge clk); #1;
      exp_push("lat_edge_n1", 16'h0000, 1'b0, 4'd0);
      exp_check();
      @(posedge clk); #1;
      exp_push("lat_edge_n2", 16'h0005, 1'b0, 4'd1);
      exp_check();
      btnd = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Held button acts once
      sw   = 16'd1;
      btnd = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      btnd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      exp_push("hold_once", 16'h0006, 1'b0, 4'd2);
      exp_check();

      commit(OP_SUB, 2'd0, 16'd10);   exp_push("sub_neg",   16'hFFFC, 1'b0, 4'd3); exp_check();
      commit(OP_LD,  2'd0, 16'h7FFF); exp_push("load_max",  16'h7FFF, 1'b0, 4'd4); exp_check();
      commit(OP_ADD, 2'd0, 16'd1);    exp_push("add_ovf",   ADD_OVF_RES, 1'b1, 4'd5); exp_check();
      press(3'b010);                  exp_push("clear",     16'h0000, 1'b0, 4'd6); exp_check();

      // Logic and shift ops; history saturates at DEPTH
      commit(OP_LD,  2'd0, 16'h00F0); exp_push("load_f0",   16'h00F0, 1'b0, 4'd7); exp_check();
      commit(OP_OR,  2'd0, 16'h000F); exp_push("or",        16'h00FF, 1'b0, 4'd8); exp_check();
      commit(OP_XOR, 2'd0, 16'h0F0F); exp_push("xor",       16'h0FF0, 1'b0, 4'd8); exp_check();
      commit(OP_AND, 2'd0, 16'hFF00); exp_push("and",       16'h0F00, 1'b0, 4'd8); exp_check();
      commit(OP_SLL, 2'd0, 16'd4);    exp_push("sll4",      16'hF000, 1'b0, 4'd8); exp_check();
      commit(OP_SRA, 2'd0, 16'd4);    exp_push("sra4",      16'hFF00, 1'b0, 4'd8); exp_check();
      commit(OP_SRA, 2'd0, 16'd20);   exp_push("sra_big",   16'hFFFF, 1'b0, 4'd8); exp_check();
      commit(OP_SLL, 2'd0, 16'd16);   exp_push("sll_big",   16'h0000, 1'b0, 4'd8); exp_check();
      commit(OP_LD,  2'd0, 16'h8000); exp_push("load_min",  16'h8000, 1'b0, 4'd8); exp_check();
      commit(OP_SUB, 2'd0, 16'd1);    exp_push("sub_ovf",   SUB_OVF_RES, 1'b1, 4'd8); exp_check();

      // Reset mid-run
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_push("reset2", 16'h0000, 1'b0, 4'd0);
      exp_check();

      // Undo across accumulators
      commit(OP_LD, 2'd1, 16'd7);     exp_push("ld_acc1",   16'h0007, 1'b0, 4'd1); exp_check();
      commit(OP_LD, 2'd2, 16'd9);     exp_push("ld_acc2",   16'h0009, 1'b0, 4'd2); exp_check();
      sel = 2'd1; #1;                 exp_push("sel_view",  16'h0007, 1'b0, 4'd2); exp_check();
      sel = 2'd2;
      press(3'b100);                  exp_push("undo1",     16'h0000, 1'b0, 4'd1); exp_check();
      sel = 2'd1; #1;                 exp_push("undo1_a1",  16'h0007, 1'b0, 4'd1); exp_check();
      press(3'b100);                  exp_push("undo2",     16'h0000, 1'b0, 4'd0); exp_check();
      press(3'b100);                  exp_push("undo3",     16'h0000, 1'b0, 4'd0); exp_check();
      sel = 2'd2; #1;                 exp_push("undo3_a2",  16'h0000, 1'b0, 4'd0); exp_check();

      // DEPTH+3 commits then DEPTH undos: oldest three entries were overwritten
      for (int i = 0; i < DEPTH + 3; i++) commit(OP_ADD, 2'd0, 16'd1);
      exp_push("depth_fill", 16'd11, 1'b0, 4'd8);
      exp_check();
      for (int i = 1; i <= DEPTH; i++) begin
         press(3'b100);
         exp_push($sformatf("depth_undo%0d", i), 16'(11 - i), 1'b0, 4'(DEPTH - i));
         exp_check();
      end
      press(3'b100);                  exp_push("depth_empty", 16'd3, 1'b0, 4'd0); exp_check();

      // ovf is sticky across ordinary commits
      commit(OP_LD,  2'd3, 16'h7FFF); exp_push("ld_acc3",   16'h7FFF, 1'b0, 4'd1); exp_check();
      commit(OP_ADD, 2'd3, 16'd1);    exp_push("acc3_ovf",  ADD_OVF_RES, 1'b1, 4'd2); exp_check();
      commit(OP_ADD, 2'd0, 16'd1);    exp_push("ovf_stick", 16'd4, 1'b1, 4'd3); exp_check();

      // Simultaneous clear, undo, commit: clear wins
      {btnl, btnc, btnr} = OP_ADD;
      sw  = 16'd1;
      sel = 2'd0;
      press(3'b111);                  exp_push("simul",     16'h0000, 1'b0, 4'd4); exp_check();
      sel = 2'd3; #1;                 exp_push("simul_a3",  ADD_OVF_RES, 1'b0, 4'd4); exp_check();

      // Reset during synchronisation drops the pending press
      {btnl, btnc, btnr} = OP_LD;
      sw   = 16'h1234;
      sel  = 2'd3;
      btnd = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      btnd  = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      exp_push("rst_mid", 16'h0000, 1'b0, 4'd0);
      exp_check();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
